// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : Universal shift register with shift/rotate/arithmetic modes,
//            parallel load, clear and a frame bit counter with done pulse.
//            Optional registered even-parity output under USR_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             data_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic [CW-1:0]    bit_cnt,
    output logic             frame_done,
    output logic             parity_out
);

    localparam logic [2:0]    c_MODE_HOLD  = 3'b000;
    localparam logic [2:0]    c_MODE_SHL   = 3'b001;
    localparam logic [2:0]    c_MODE_SHR   = 3'b010;
    localparam logic [2:0]    c_MODE_ROL   = 3'b011;
    localparam logic [2:0]    c_MODE_ROR   = 3'b100;
    localparam logic [2:0]    c_MODE_ASR   = 3'b101;
    localparam logic [2:0]    c_MODE_LOAD  = 3'b110;
    localparam logic [2:0]    c_MODE_CLEAR = 3'b111;
    localparam logic [CW-1:0] c_CNT_MAX    = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_data;
    logic             r_sout;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_next_data;
    logic             w_next_sout;
    logic [CW-1:0]    w_next_cnt;
    logic             w_next_done;
    logic             w_shift;

    always_comb begin
        w_next_data = r_data;
        w_next_sout = r_sout;
        w_next_cnt  = r_cnt;
        w_next_done = 1'b0;
        w_shift     = 1'b0;
        if (enable) begin
            case (mode)
                c_MODE_HOLD: begin
                    w_next_data = r_data;
                end
                c_MODE_SHL: begin
                    w_next_data = {r_data[WIDTH-2:0], data_in};
                    w_next_sout = r_data[WIDTH-1];
                    w_shift     = 1'b1;
                end
                c_MODE_SHR: begin
                    w_next_data = {data_in, r_data[WIDTH-1:1]};
                    w_next_sout = r_data[0];
                    w_shift     = 1'b1;
                end
                c_MODE_ROL: begin
                    w_next_data = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                    w_next_sout = r_data[WIDTH-1];
                    w_shift     = 1'b1;
                end
                c_MODE_ROR: begin
                    w_next_data = {r_data[0], r_data[WIDTH-1:1]};
                    w_next_sout = r_data[0];
                    w_shift     = 1'b1;
                end
                c_MODE_ASR: begin
                    w_next_data = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
                    w_next_sout = r_data[0];
                    w_shift     = 1'b1;
                end
                c_MODE_LOAD: begin
                    w_next_data = par_in;
                    w_next_cnt  = '0;
                end
                c_MODE_CLEAR: begin
                    w_next_data = '0;
                    w_next_sout = 1'b0;
                    w_next_cnt  = '0;
                end
                default: begin
                    w_next_data = r_data;
                end
            endcase
        end
        // Explicit wrap keeps non-power-of-two widths from ever reaching WIDTH
        if (w_shift) begin
            if (r_cnt == c_CNT_MAX) begin
                w_next_cnt  = '0;
                w_next_done = 1'b1;
            end else begin
                w_next_cnt  = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_sout <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_data <= w_next_data;
            r_sout <= w_next_sout;
            r_cnt  <= w_next_cnt;
            r_done <= w_next_done;
        end
    end

`ifdef USR_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_next_data;
        end
    end

    assign parity_out = r_parity;
`else
    assign parity_out = 1'b0;
`endif

    assign data_out   = r_data;
    assign serial_out = r_sout;
    assign bit_cnt    = r_cnt;
    assign frame_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// Module   : tb_univ_shift_reg
// Purpose  : Scoreboard bench for univ_shift_reg at WIDTH=8 and WIDTH=5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

    logic       clk;
    logic       rst;
    logic       en8, en5;
    logic [2:0] mode;
    logic       din;
    logic [7:0] par8;
    logic [4:0] par5;

    logic [7:0] data8;
    logic       sout8, done8, par_o8;
    logic [2:0] cnt8;
    logic [4:0] data5;
    logic       sout5, done5, par_o5;
    logic [2:0] cnt5;

    typedef struct {
        bit         sel5;
        logic [7:0] d;
        logic       s;
        logic [2:0] c;
        logic       f;
        logic       p;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    univ_shift_reg #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .reset      (rst),
        .enable     (en8),
        .mode       (mode),
        .data_in    (din),
        .par_in     (par8),
        .data_out   (data8),
        .serial_out (sout8),
        .bit_cnt    (cnt8),
        .frame_done (done8),
        .parity_out (par_o8)
    );

    univ_shift_reg #(.WIDTH(5)) u_dut5 (
        .clk        (clk),
        .reset      (rst),
        .enable     (en5),
        .mode       (mode),
        .data_in    (din),
        .par_in     (par5),
        .data_out   (data5),
        .serial_out (sout5),
        .bit_cnt    (cnt5),
        .frame_done (done5),
        .parity_out (par_o5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_par(input logic [7:0] d);
`ifdef USR_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle of stimulus and queue the response expected after the edge
    task automatic op(input bit sel5, input logic r, input logic e, input logic [2:0] m,
                      input logic di, input logic [7:0] pi,
                      input logic [7:0] ed, input logic es, input logic [2:0] ec,
                      input logic ef, input string nm);
        exp_t x;
        @(negedge clk);
        #1;
        rst  = r;
        en8  = sel5 ? 1'b0 : e;
        en5  = sel5 ? e : 1'b0;
        mode = m;
        din  = di;
        par8 = pi;
        par5 = pi[4:0];
        @(posedge clk);
        #1;
        x.sel5 = sel5; x.d = ed; x.s = es; x.c = ec; x.f = ef;
        x.p = exp_par(ed); x.name = nm;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [13:0] act, req;
            e = q.pop_front();
            if (e.sel5) act = {3'b000, data5, sout5, cnt5, done5, par_o5};
            else        act = {data8, sout8, cnt8, done8, par_o8};
            req = {e.d, e.s, e.c, e.f, e.p};
            n_checks++;
            if (act !== req) begin
                n_errors++;
                $display("FAIL %s: got d=%h s=%b cnt=%0d done=%b par=%b, want d=%h s=%b cnt=%0d done=%b par=%b",
                         e.name, act[13:6], act[5], act[4:2], act[1], act[0],
                         e.d, e.s, e.c, e.f, e.p);
            end
        end
    end

    initial begin
        rst = 1'b1; en8 = 1'b1; en5 = 1'b0; mode = 3'b001; din = 1'b1;
        par8 = 8'h00; par5 = 5'h00;

        // Reset wins over enable and a shift mode
        op(0, 1, 1, 3'b001, 1, 8'h00, 8'h00, 0, 0, 0, "reset0");
        op(0, 1, 1, 3'b001, 1, 8'h00, 8'h00, 0, 0, 0, "reset1");

        op(0, 0, 1, 3'b110, 0, 8'hA5, 8'hA5, 0, 0, 0, "load_a5");
        op(0, 0, 1, 3'b001, 0, 8'h00, 8'h4A, 1, 1, 0, "shl1");
        op(0, 0, 1, 3'b001, 0, 8'h00, 8'h94, 0, 2, 0, "shl2");
        op(0, 0, 1, 3'b001, 0, 8'h00, 8'h28, 1, 3, 0, "shl3");
        op(0, 0, 1, 3'b001, 0, 8'h00, 8'h50, 0, 4, 0, "shl4");
        op(0, 0, 1, 3'b001, 0, 8'h00, 8'hA0, 0, 5, 0, "shl5");
        op(0, 0, 1, 3'b001, 0, 8'h00, 8'h40, 1, 6, 0, "shl6");
        op(0, 0, 1, 3'b001, 0, 8'h00, 8'h80, 0, 7, 0, "shl7");
        op(0, 0, 1, 3'b001, 0, 8'h00, 8'h00, 1, 0, 1, "shl8_done");
        op(0, 0, 1, 3'b000, 0, 8'h00, 8'h00, 1, 0, 0, "hold_after_done");

        op(0, 0, 1, 3'b110, 0, 8'h81, 8'h81, 1, 0, 0, "load_81");
        op(0, 0, 1, 3'b011, 0, 8'h00, 8'h03, 1, 1, 0, "rol");
        op(0, 0, 1, 3'b100, 0, 8'h00, 8'h81, 1, 2, 0, "ror1");
        op(0, 0, 1, 3'b100, 0, 8'h00, 8'hC0, 1, 3, 0, "ror2");

        op(0, 0, 1, 3'b110, 0, 8'h80, 8'h80, 1, 0, 0, "load_80");
        op(0, 0, 1, 3'b101, 0, 8'h00, 8'hC0, 0, 1, 0, "asr1");
        op(0, 0, 1, 3'b101, 0, 8'h00, 8'hE0, 0, 2, 0, "asr2");
        op(0, 0, 1, 3'b010, 0, 8'h00, 8'h70, 0, 3, 0, "shr");
        op(0, 0, 1, 3'b111, 0, 8'h00, 8'h00, 0, 0, 0, "clear");

        op(0, 0, 1, 3'b110, 0, 8'h07, 8'h07, 0, 0, 0, "load_07");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h0F, 0, 1, 0, "shl_par");

        // Three shifts, then a stall, then reset discards the partial frame
        op(0, 0, 1, 3'b111, 0, 8'h00, 8'h00, 0, 0, 0, "clear2");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h01, 0, 1, 0, "pre1");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h03, 0, 2, 0, "pre2");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h07, 0, 3, 0, "pre3");
        for (int i = 0; i < 4; i++)
            op(0, 0, 0, 3'b001, 1, 8'h00, 8'h07, 0, 3, 0, "stall");
        op(0, 1, 1, 3'b001, 1, 8'h00, 8'h00, 0, 0, 0, "midframe_reset");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h01, 0, 1, 0, "post1");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h03, 0, 2, 0, "post2");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h07, 0, 3, 0, "post3");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h0F, 0, 4, 0, "post4");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h1F, 0, 5, 0, "post5");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h3F, 0, 6, 0, "post6");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'h7F, 0, 7, 0, "post7");
        op(0, 0, 1, 3'b001, 1, 8'h00, 8'hFF, 0, 0, 1, "post8_done");

        // Back-to-back frame: shift zeros into 0xFF
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            d = 8'hFF << (i + 1);
            op(0, 0, 1, 3'b001, 0, 8'h00, d, 1, 3'((i + 1) % 8), (i == 7), "b2b");
        end

        // Width 5: frame_done after shifts 5 and 10
        op(1, 0, 1, 3'b001, 1, 8'h00, 8'h01, 0, 1, 0, "w5_s1");
        op(1, 0, 1, 3'b001, 1, 8'h00, 8'h03, 0, 2, 0, "w5_s2");
        op(1, 0, 1, 3'b001, 1, 8'h00, 8'h07, 0, 3, 0, "w5_s3");
        op(1, 0, 1, 3'b001, 1, 8'h00, 8'h0F, 0, 4, 0, "w5_s4");
        op(1, 0, 1, 3'b001, 1, 8'h00, 8'h1F, 0, 0, 1, "w5_s5_done");
        op(1, 0, 1, 3'b001, 1, 8'h00, 8'h1F, 1, 1, 0, "w5_s6");
        op(1, 0, 1, 3'b001, 1, 8'h00, 8'h1F, 1, 2, 0, "w5_s7");
        op(1, 0, 1, 3'b001, 1, 8'h00, 8'h1F, 1, 3, 0, "w5_s8");
        op(1, 0, 1, 3'b001, 1, 8'h00, 8'h1F, 1, 4, 0, "w5_s9");
        op(1, 0, 1, 3'b001, 1, 8'h00, 8'h1F, 1, 0, 1, "w5_s10_done");
        op(1, 0, 1, 3'b000, 1, 8'h00, 8'h1F, 1, 0, 0, "w5_hold");

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, successor to the fixed 8-bit shift_reg used on the DE-series board top.
- Adds selectable shift/rotate/arithmetic modes, parallel load and clear.
- Adds a frame bit counter with a one-cycle frame-complete pulse for serial framing, e.g. feeding scan-code style byte streams.
- Sits between board I/O (switches/keys) or a serial source and downstream display/decode logic.

Parameters:
WIDTH, 8, register width in bits; legal range 2..32.
CW, $clog2(WIDTH), bit counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock, single clock domain.
reset  input  1  synchronous, active-high reset.
enable  input  1  operation qualifier; low = hold everything.
mode  input  3  operation select (encoding below).
data_in  input  1  serial input bit.
par_in  input  WIDTH  parallel load value.
data_out  output  WIDTH  register contents (registered).
serial_out  output  1  bit most recently shifted/rotated out (registered).
bit_cnt  output  CW  shifts performed in current frame.
frame_done  output  1  one-cycle pulse when a frame of WIDTH shifts completes.
parity_out  output  1  even-parity bit of data_out (optional feature, see below).

Behaviour:
- Reset is synchronous and active-high: on a clk edge with reset=1, data_out=0, serial_out=0, bit_cnt=0, frame_done=0, parity_out=0. Reset has priority over enable and mode. Reset mid-frame discards the partial count; no frame_done is issued.
- All outputs are registered; the effect of an operation is visible one clk after the sampling edge.
- enable=0: data_out, serial_out and bit_cnt hold; frame_done=0.
- enable=1, mode encoding, R = data_out:
  - 000 HOLD: no change; bit_cnt holds; frame_done=0.
  - 001 SHL: R <= {R[W-2:0], data_in}; serial_out <= R[W-1].
  - 010 SHR: R <= {data_in, R[W-1:1]}; serial_out <= R[0].
  - 011 ROL: R <= {R[W-2:0], R[W-1]}; serial_out <= R[W-1].
  - 100 ROR: R <= {R[0], R[W-1:1]}; serial_out <= R[0].
  - 101 ASR: R <= {R[W-1], R[W-1:1]}; serial_out <= R[0].
  - 110 LOAD: R <= par_in; serial_out holds; bit_cnt <= 0; frame_done=0.
  - 111 CLEAR: R <= 0; serial_out <= 0; bit_cnt <= 0; frame_done=0.
- Modes 001-101 are "shift ops". Each shift op increments bit_cnt modulo WIDTH.
- On the shift op that takes bit_cnt from WIDTH-1 to 0, frame_done=1 for exactly the following cycle. It is 0 in all other cycles.
- WIDTH not a power of two: bit_cnt wraps explicitly at WIDTH-1 and never reaches WIDTH.
- Back-to-back frames: continuous shift ops give frame_done every WIDTH cycles with no dead cycle.
- Mode may change on any cycle. Mixing shift-op types within a frame still counts toward the frame.
- Inputs are assumed synchronous to clk. Debouncing and synchronising board keys is the instantiating top's responsibility.

Optional Feature:
Macro USR_PARITY_EN.
- Defined: parity_out is a register updated on the same edge as data_out, holding the XOR reduction of the new data_out value. It therefore always equals ^data_out. Reset value is 0.
- Undefined: the port is still present but tied to 0, and no parity logic is synthesised.

Test Plan:
WIDTH=8 unless noted.
- Reset: assert reset 2 cycles with enable=1, mode=001 -> data_out=0x00, serial_out=0, bit_cnt=0, frame_done=0, parity_out=0.
- LOAD 0xA5, then 8x SHL with data_in=0 -> serial_out sequence 1,0,1,0,0,1,0,1; data_out=0x00; bit_cnt 1..7 then 0; frame_done high only after the 8th shift.
- LOAD 0x81, ROL once -> 0x03, serial_out=1. Then ROR twice -> 0xC0.
- LOAD 0x80, ASR twice -> 0xC0 then 0xE0, serial_out=0. Then SHR with data_in=0 -> 0x70.
- Do 3 shifts, then enable=0 for 4 cycles with mode=001 -> data_out and bit_cnt=3 unchanged. Then reset -> bit_cnt=0, and no frame_done over the next 7 shifts.
- USR_PARITY_EN defined: LOAD 0x07 -> parity_out=1; SHL with data_in=1 -> 0x0F, parity_out=0. Also run WIDTH=5 with 10 shifts -> frame_done pulses after the 5th and 10th shifts.
